branch_seq: RTL and testbench

BRANCH_SEQ -- requirements
Module: branch_seq

---
 rtl/branch_seq.sv | 136 +++++++++++++
 tb/tb_branch_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_seq.sv
// Branch sequencer: steps the datapath through T3..T6 for a conditional branch.
// Tracks completed and taken branch counts with saturation.
module branch_seq #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             hold,
   input  logic [31:0]      ir,
   input  logic             con,
   output logic             gra,
   output logic             r_out,
   output logic             con_in,
   output logic             pc_out,
   output logic             y_in,
   output logic             c_out,
   output logic             add,
   output logic             z_in,
   output logic             zlow_out,
   output logic             pc_in,
   output logic             busy,
   output logic             done,
   output logic             taken,
   output logic             bad_cond,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      T3,
      T4,
      T5,
      T6,
      DONE
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [3:0] cc_q;
   logic       con_q;
   logic       bad_flag;
   logic       accept;

   // cc_q is kept for debug visibility; only ir[22:19] feeds the decode
   logic unused_bits;
   assign unused_bits = ^{ir[31:23], ir[18:0], cc_q};

   assign accept = (state_q == IDLE) && start && !hold;

   // next-state: advance one step per cycle unless stalled
   always_comb begin
      state_d = state_q;
      if (!hold) begin
         unique case (state_q)
            IDLE: if (start) state_d = (ir[22:19] <= 4'd3) ? T3 : DONE;
            T3:   state_d = T4;
            T4:   state_d = T5;
            T5:   state_d = T6;
            T6:   state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // state, captured condition info and saturating counters
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q    <= IDLE;
         cc_q       <= '0;
         con_q      <= 1'b0;
         bad_flag   <= 1'b0;
         branch_cnt <= '0;
         taken_cnt  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cc_q     <= ir[22:19];
            bad_flag <= (ir[22:19] > 4'd3);
            con_q    <= 1'b0;
         end
         if (!hold && state_q == T4) con_q <= con;
         if (!hold && state_q == T6) begin
            if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
            if (con_q && taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
         end
      end
   end

   // Moore decode of strobes and status from the current state
   always_comb begin
      gra      = 1'b0;
      r_out    = 1'b0;
      con_in   = 1'b0;
      pc_out   = 1'b0;
      y_in     = 1'b0;
      c_out    = 1'b0;
      add      = 1'b0;
      z_in     = 1'b0;
      zlow_out = 1'b0;
      pc_in    = 1'b0;
      done     = 1'b0;
      taken    = 1'b0;
      bad_cond = 1'b0;
      busy     = (state_q != IDLE);
      unique case (state_q)
         T3: begin
            gra    = 1'b1;
            r_out  = 1'b1;
            con_in = 1'b1;
         end
         T4: begin
            pc_out = 1'b1;
            y_in   = 1'b1;
         end
         T5: begin
            c_out = 1'b1;
            add   = 1'b1;
            z_in  = 1'b1;
         end
         T6: begin
            zlow_out = 1'b1;
            pc_in    = con_q;
         end
         DONE: begin
            done     = 1'b1;
            taken    = con_q;
            bad_cond = bad_flag;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_branch_seq.sv
// Directed bench for branch_seq with a done-event scoreboard.
// A second instance with 2-bit counters covers saturation.
module tb_branch_seq;

   logic        clk = 1'b0;
   logic        clear, start, hold, con;
   logic [31:0] ir;

   logic gra, r_out, con_in, pc_out, y_in, c_out, add, z_in, zlow_out, pc_in;
   logic busy, done, taken, bad_cond;
   logic [15:0] branch_cnt, taken_cnt;

   logic [9:0] s2;
   logic [3:0] st2;
   logic [1:0] bc2, tc2;

   logic [9:0] sv;
   logic [3:0] st;

   int errors = 0;
   int checks = 0;
   int mb = 0;
   int mt = 0;

   typedef struct packed {
      logic        tk;
      logic        bad;
      logic [15:0] bc;
      logic [15:0] tc;
   } exp_t;

   exp_t q[$];

   localparam logic [9:0] S_T3 = 10'b1110000000;
   localparam logic [9:0] S_T4 = 10'b0001100000;
   localparam logic [9:0] S_T5 = 10'b0000011100;
   localparam logic [9:0] S_T6 = 10'b0000000010;

   always #5 clk = ~clk;

   branch_seq dut (
      .clock(clk), .clear(clear), .start(start), .hold(hold),
      .ir(ir), .con(con),
      .gra(gra), .r_out(r_out), .con_in(con_in), .pc_out(pc_out),
      .y_in(y_in), .c_out(c_out), .add(add), .z_in(z_in),
      .zlow_out(zlow_out), .pc_in(pc_in),
      .busy(busy), .done(done), .taken(taken), .bad_cond(bad_cond),
      .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
   );

   branch_seq #(.CNT_W(2)) dut2 (
      .clock(clk), .clear(clear), .start(start), .hold(hold),
      .ir(ir), .con(con),
      .gra(s2[9]), .r_out(s2[8]), .con_in(s2[7]), .pc_out(s2[6]),
      .y_in(s2[5]), .c_out(s2[4]), .add(s2[3]), .z_in(s2[2]),
      .zlow_out(s2[1]), .pc_in(s2[0]),
      .busy(st2[3]), .done(st2[2]), .taken(st2[1]), .bad_cond(st2[0]),
      .branch_cnt(bc2), .taken_cnt(tc2)
   );

   assign sv = {gra, r_out, con_in, pc_out, y_in,
                c_out, add, z_in, zlow_out, pc_in};
   assign st = {busy, done, taken, bad_cond};

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: every done pulse must match the oldest expectation
   always @(negedge clk) begin
      if (clear === 1'b1 && done === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_taken", {31'd0, taken}, {31'd0, e.tk});
            chk("sb_bad", {31'd0, bad_cond}, {31'd0, e.bad});
            chk("sb_bcnt", {16'd0, branch_cnt}, {16'd0, e.bc});
            chk("sb_tcnt", {16'd0, taken_cnt}, {16'd0, e.tc});
         end
      end
   end

   task automatic run_valid(input logic [3:0] cc, input logic c4,
                            input logic c5);
      ir = $urandom;
      ir[22:19] = cc;
      con = c4;
      start = 1'b1;
      mb++;
      if (c4) mt++;
      q.push_back('{c4, 1'b0, mb[15:0], mt[15:0]});
      tick();
      start = 1'b0;
      chk("t3_strobes", sv, S_T3);
      chk("t3_busy", st, 4'b1000);
      tick();
      chk("t4_strobes", sv, S_T4);
      tick();
      con = c5;
      chk("t5_strobes", sv, S_T5);
      tick();
      chk("t6_strobes", sv, S_T6 | {9'd0, c4});
      tick();
      chk("done_lat", {31'd0, done}, 32'd1);
      chk("done_strobes", sv, 10'd0);
      tick();
      chk("idle_busy", st, 4'b0000);
   endtask

   initial begin
      clear = 1'b0;
      start = 1'b0;
      hold  = 1'b0;
      ir    = '0;
      con   = 1'b0;
      #3;
      chk("rst_strobes", sv, 10'd0);
      chk("rst_status", st, 4'd0);
      chk("rst_cnt", {branch_cnt, taken_cnt}, 32'd0);
      tick();
      tick();
      clear = 1'b1;
      chk("post_rst_status", st, 4'd0);

      // brzr taken
      run_valid(4'b0000, 1'b1, 1'b1);
      chk("brzr_bcnt", branch_cnt, 32'd1);
      chk("brzr_tcnt", taken_cnt, 32'd1);

      // brmi not taken, con flips after the sample point
      run_valid(4'b0011, 1'b0, 1'b1);
      chk("brmi_tcnt", taken_cnt, 32'd1);

      // bad condition code
      ir = '0;
      ir[22:19] = 4'b0101;
      con = 1'b1;
      start = 1'b1;
      q.push_back('{1'b0, 1'b1, mb[15:0], mt[15:0]});
      tick();
      start = 1'b0;
      chk("bad_lat", st, 4'b1101);
      chk("bad_strobes", sv, 10'd0);
      tick();
      chk("bad_idle", st, 4'd0);
      chk("bad_cnt", {branch_cnt, taken_cnt}, {16'd2, 16'd1});

      // start during hold in IDLE is ignored
      ir[22:19] = 4'd1;
      start = 1'b1;
      hold = 1'b1;
      tick();
      start = 1'b0;
      hold = 1'b0;
      chk("hold_idle_start", st, 4'd0);

      // stall three cycles in T5
      ir[22:19] = 4'd1;
      con = 1'b1;
      start = 1'b1;
      mb++;
      mt++;
      q.push_back('{1'b1, 1'b0, mb[15:0], mt[15:0]});
      tick();
      start = 1'b0;
      chk("st_t3", sv, S_T3);
      tick();
      chk("st_t4", sv, S_T4);
      tick();
      con = 1'b0;
      chk("st_t5", sv, S_T5);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start = 1'b1;
         tick();
         chk("st_hold_t5", sv, S_T5);
         chk("st_hold_busy", st, 4'b1000);
      end
      hold = 1'b0;
      start = 1'b0;
      tick();
      chk("st_t6", sv, S_T6 | 10'd1);
      tick();
      chk("st_done_c8", st, 4'b1110);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("done_start_ign", st, 4'd0);
      chk("st_cnt", {branch_cnt, taken_cnt}, {16'd3, 16'd2});

      // abort with clear during T6
      ir[22:19] = 4'd2;
      con = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("ab_t6_pcin", sv, S_T6 | 10'd1);
      clear = 1'b0;
      #1;
      chk("ab_async", {22'd0, sv, st}, 32'd0);
      chk("ab_cnt", {branch_cnt, taken_cnt}, 32'd0);
      mb = 0;
      mt = 0;
      tick();
      tick();
      clear = 1'b1;
      chk("ab_no_done", st, 4'd0);

      // saturation on the narrow instance
      for (int i = 0; i < 5; i++) run_valid(4'd0, 1'b1, 1'b1);
      chk("sat_bcnt2", {30'd0, bc2}, 32'd3);
      chk("sat_tcnt2", {30'd0, tc2}, 32'd3);
      chk("sat_bcnt16", branch_cnt, 32'd5);

      tick();
      chk("sb_drained", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
